// File: rtl/cix32_defines.sv
// Shared types and constants for the CIX32 memory arbiter.
package cix32_defines;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

endpackage

// File: rtl/cix32_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port, with a bus timeout.
// Optional round-robin tie-breaking is enabled by defining CIX32_ARB_RR_EN.
module cix32_mem_arbiter
  import cix32_defines::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  input  logic        d_we,
  output logic        d_ready,
  output logic [31:0] rsp_rdata,
  output logic        bus_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        owner
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  arb_state_t  state_reg, state_next;
  logic        owner_reg, owner_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  wstrb_reg, wstrb_next;
  logic        we_reg, we_next;
  logic [31:0] rdata_reg, rdata_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        err_reg, err_next;
  logic        grant_d;

  // On a tie, round-robin hands the grant to whichever port did not own last.
`ifdef CIX32_ARB_RR_EN
  assign grant_d = d_req && (!if_req || (owner_reg == OWNER_IF));
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ARB_IDLE;
      owner_reg <= OWNER_IF;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
      we_reg    <= 1'b0;
      rdata_reg <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wstrb_reg <= wstrb_next;
      we_reg    <= we_next;
      rdata_reg <= rdata_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    wstrb_next = wstrb_reg;
    we_next    = we_reg;
    rdata_next = rdata_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (if_req || d_req) begin
          state_next = ARB_BUSY;
          if (grant_d) begin
            owner_next = OWNER_D;
            addr_next  = d_addr;
            wdata_next = d_wdata;
            wstrb_next = d_wstrb;
            we_next    = d_we;
          end else begin
            owner_next = OWNER_IF;
            addr_next  = if_addr;
            wdata_next = '0;
            wstrb_next = 4'hF;
            we_next    = 1'b0;
          end
        end
      end
      ARB_BUSY: begin
        // A response arriving on the final wait cycle still wins over the abort.
        if (mem_ready) begin
          rdata_next = mem_rdata;
          state_next = ARB_DONE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          err_next   = 1'b1;
          rdata_next = 32'hFFFF_FFFF;
          state_next = ARB_DONE;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ARB_DONE: begin
        state_next = ARB_IDLE;
        cnt_next   = '0;
        err_next   = 1'b0;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  assign mem_req   = (state_reg == ARB_BUSY);
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_wstrb = wstrb_reg;
  assign mem_we    = we_reg;
  assign rsp_rdata = rdata_reg;
  assign owner     = owner_reg;
  assign if_ready  = (state_reg == ARB_DONE) && (owner_reg == OWNER_IF);
  assign d_ready   = (state_reg == ARB_DONE) && (owner_reg == OWNER_D);
  assign bus_err   = (state_reg == ARB_DONE) && err_reg;

endmodule

// File: tb/tb_cix32_mem_arbiter.sv
// Directed self-checking bench for cix32_mem_arbiter (TIMEOUT_CYCLES = 4).
module tb_cix32_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_we;
  logic        d_ready;
  logic [31:0] rsp_rdata;
  logic        bus_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        owner;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cix32_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_we(d_we), .d_ready(d_ready),
    .rsp_rdata(rsp_rdata), .bus_err(bus_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .owner(owner)
  );

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; d_req = 0; d_addr = 0; d_wdata = 0;
    d_wstrb = 0; d_we = 0; mem_rdata = 0; mem_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if ({if_ready, d_ready, bus_err, mem_req, mem_we, owner} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=000000", {if_ready, d_ready, bus_err, mem_req, mem_we, owner});
    end
    checks++;
    if ({mem_addr, mem_wdata, rsp_rdata, mem_wstrb} !== 100'b0) begin
      errors++;
      $display("FAIL reset_data addr=%h wdata=%h rdata=%h wstrb=%h exp all zero",
               mem_addr, mem_wdata, rsp_rdata, mem_wstrb);
    end
    rst_n = 1;
    @(negedge clk);
    $display("reset: done");
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 32'h100;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_addr, mem_we, mem_wstrb, if_ready} !== {1'b1, 32'h100, 1'b0, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL fetch_busy req=%b addr=%h we=%b wstrb=%h rdy=%b exp 1/00000100/0/f/0",
               mem_req, mem_addr, mem_we, mem_wstrb, if_ready);
    end
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({if_ready, d_ready, bus_err, mem_req, owner, rsp_rdata} !== {5'b10000, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL fetch_done ifr=%b dr=%b err=%b req=%b own=%b rdata=%h exp 1/0/0/0/0/deadbeef",
               if_ready, d_ready, bus_err, mem_req, owner, rsp_rdata);
    end
    if_req = 0; mem_ready = 0; mem_rdata = 0;
    @(negedge clk);
    checks++;
    if ({if_ready, mem_req} !== 2'b00) begin
      errors++;
      $display("FAIL fetch_after ifr=%b req=%b exp 0/0", if_ready, mem_req);
    end
    $display("fetch: addr=00000100 rdata=%h", rsp_rdata);
  endtask

  task automatic test_store();
    d_req = 1; d_addr = 32'h2000; d_wdata = 32'h12345678; d_wstrb = 4'b0011; d_we = 1;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== {2'b11, 32'h2000, 32'h12345678, 4'b0011}) begin
      errors++;
      $display("FAIL store_busy req=%b we=%b addr=%h wdata=%h wstrb=%b exp 1/1/00002000/12345678/0011",
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
    end
    // Disturb the request side mid-transaction; the bus must stay put.
    d_addr = 32'hFFFF_0000; d_wdata = 0; d_we = 0; d_wstrb = 4'hF; if_req = 1; if_addr = 32'h77;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, owner} !== {2'b11, 32'h2000, 32'h12345678, 4'b0011, 1'b1}) begin
      errors++;
      $display("FAIL store_hold req=%b we=%b addr=%h wdata=%h wstrb=%b own=%b exp 1/1/00002000/12345678/0011/1",
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, owner);
    end
    mem_ready = 1; mem_rdata = 32'h55;
    @(negedge clk);
    checks++;
    if ({d_ready, if_ready, bus_err, mem_req} !== 4'b1000) begin
      errors++;
      $display("FAIL store_done dr=%b ifr=%b err=%b req=%b exp 1/0/0/0", d_ready, if_ready, bus_err, mem_req);
    end
    d_req = 0; if_req = 0; mem_ready = 0;
    @(negedge clk);
    checks++;
    if ({d_ready, bus_err} !== 2'b00) begin
      errors++;
      $display("FAIL store_once dr=%b err=%b exp 0/0", d_ready, bus_err);
    end
    $display("store: addr=00002000 wdata=12345678 wstrb=0011 done");
  endtask

  task automatic test_idle_ready();
    mem_ready = 1; mem_rdata = 32'hCAFE0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, if_ready, d_ready, bus_err} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_ready cyc=%0d req=%b ifr=%b dr=%b err=%b exp 0/0/0/0",
                 i, mem_req, if_ready, d_ready, bus_err);
      end
    end
    mem_ready = 0; mem_rdata = 0;
    $display("idle_ready: stray mem_ready ignored");
  endtask

  task automatic test_priority();
    logic exp_own;
    int n;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    if_req = 1; if_addr = 32'h300;
    d_req = 1; d_addr = 32'h400; d_we = 0; d_wstrb = 4'hF; d_wdata = 0;
    for (int t = 0; t < 4; t++) begin
`ifdef CIX32_ARB_RR_EN
      exp_own = (t % 2 == 0);
`else
      exp_own = 1'b1;
`endif
      n = 0;
      while (mem_req !== 1'b1 && n < 6) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n >= 6) begin
        errors++;
        $display("FAIL prio_wait txn=%0d mem_req never rose within 6 cycles", t);
      end
      checks++;
      if ({owner, mem_addr} !== {exp_own, (exp_own ? 32'h400 : 32'h300)}) begin
        errors++;
        $display("FAIL prio_owner txn=%0d own=%b addr=%h exp own=%b", t, owner, mem_addr, exp_own);
      end
      mem_ready = 1; mem_rdata = 32'hA0 + t;
      @(negedge clk);
      checks++;
      if ({d_ready, if_ready, rsp_rdata} !== {exp_own, ~exp_own, 32'hA0 + t}) begin
        errors++;
        $display("FAIL prio_done txn=%0d dr=%b ifr=%b rdata=%h exp dr=%b rdata=%h",
                 t, d_ready, if_ready, rsp_rdata, exp_own, 32'hA0 + t);
      end
      mem_ready = 0;
      $display("priority: txn=%0d owner=%b", t, owner);
      @(negedge clk);
    end
    if_req = 0; d_req = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n;
    for (int r = 0; r < 2; r++) begin
      d_req = 1; d_addr = 32'h40; d_we = 0; d_wstrb = 4'hF; mem_ready = 0;
      n = 0;
      @(negedge clk);
      while (mem_req === 1'b1 && n < 10) begin
        n++;
        @(negedge clk);
      end
      checks++;
      if (n !== TO) begin
        errors++;
        $display("FAIL timeout_len run=%0d busy_cycles=%0d exp %0d", r, n, TO);
      end
      checks++;
      if ({d_ready, bus_err, if_ready, rsp_rdata} !== {3'b110, 32'hFFFF_FFFF}) begin
        errors++;
        $display("FAIL timeout_done run=%0d dr=%b err=%b ifr=%b rdata=%h exp 1/1/0/ffffffff",
                 r, d_ready, bus_err, if_ready, rsp_rdata);
      end
      d_req = 0;
      @(negedge clk);
      checks++;
      if ({d_ready, bus_err, mem_req} !== 3'b000) begin
        errors++;
        $display("FAIL timeout_after run=%0d dr=%b err=%b req=%b exp 0/0/0", r, d_ready, bus_err, mem_req);
      end
      $display("timeout: run=%0d busy_cycles=%0d", r, n);
    end
  endtask

  task automatic test_reset_mid();
    if_req = 1; if_addr = 32'h500;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h500}) begin
      errors++;
      $display("FAIL rstmid_busy req=%b addr=%h exp 1/00000500", mem_req, mem_addr);
    end
    rst_n = 0; mem_ready = 1; mem_rdata = 32'h99;
    #1;
    checks++;
    if ({mem_req, owner, mem_addr, rsp_rdata, mem_wstrb, if_ready, d_ready} !== 72'b0) begin
      errors++;
      $display("FAIL rstmid_async req=%b own=%b addr=%h rdata=%h wstrb=%h ifr=%b dr=%b exp all zero",
               mem_req, owner, mem_addr, rsp_rdata, mem_wstrb, if_ready, d_ready);
    end
    @(negedge clk);
    rst_n = 1; if_req = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({if_ready, d_ready, bus_err, mem_req} !== 4'b0000) begin
        errors++;
        $display("FAIL rstmid_quiet cyc=%0d ifr=%b dr=%b err=%b req=%b exp 0/0/0/0",
                 i, if_ready, d_ready, bus_err, mem_req);
      end
    end
    mem_ready = 0;
    $display("reset_mid: transaction abandoned");
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_idle_ready();
    test_priority();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cix32_mem_arbiter.md
CIX32_MEM_ARBITER -- requirements
Module: cix32_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the number of BUSY cycles without mem_ready before the transaction is aborted; legal range is 2..65535.
REQ-002 clk  in  1  clock, all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 if_req  in  1  instruction-fetch read request, held until if_ready.
REQ-005 if_addr  in  32  instruction-fetch physical address.
REQ-006 if_ready  out  1  one-cycle completion pulse to the fetch port.
REQ-007 d_req  in  1  data (LSU) request, held until d_ready.
REQ-008 d_addr  in  32  data physical address.
REQ-009 d_wdata  in  32  data store value.
REQ-010 d_wstrb  in  4  data byte strobes.
REQ-011 d_we  in  1  data write enable.
REQ-012 d_ready  out  1  one-cycle completion pulse to the data port.
REQ-013 rsp_rdata  out  32  read data for the completing port, valid while that port's ready is high.
REQ-014 bus_err  out  1  one-cycle pulse, coincident with ready, when the transaction timed out.
REQ-015 mem_req, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0], mem_we  out  shared memory request.
REQ-016 mem_rdata[31:0], mem_ready  in  shared memory response.
REQ-017 owner  out  1  current or last grant: 0 = fetch, 1 = data.

Function
REQ-018 The FSM shall have three states: ARB_IDLE, ARB_BUSY and ARB_DONE.
REQ-019 In IDLE with any request pending, the arbiter shall select a winner, register owner, and latch that port's addr, wdata, wstrb and we; for fetch, we=0 and wstrb=4'hF. It then moves to BUSY.
REQ-020 In BUSY, mem_req shall be 1 and mem_* shall be driven from the latched fields only; in every other state mem_req shall be 0.
REQ-021 In BUSY, when mem_ready=1:
- register mem_rdata into rsp_rdata;
- go to DONE.
REQ-022 In BUSY, a 16-bit wait counter shall increment each cycle mem_ready=0. When it reaches TIMEOUT_CYCLES-1:
- set a pending error flag;
- load rsp_rdata with 32'hFFFF_FFFF;
- go to DONE.
REQ-023 In DONE, the owner's ready shall be 1 for exactly one cycle, and bus_err shall equal the error flag. All requests are ignored in DONE. The FSM then returns to IDLE and the counter and error flag clear.
REQ-024 Minimum latency: request sampled in IDLE at cycle N, mem_req at N+1, mem_ready at N+1 gives ready at N+2.
REQ-025 Request changes in BUSY or DONE shall not alter mem_* outputs.
REQ-026 mem_ready seen outside BUSY shall be ignored.
REQ-027 Priority without CIX32_ARB_RR_EN: data beats fetch whenever both requests are high in IDLE.

Reset
REQ-028 Reset forces:
- state = IDLE;
- if_ready, d_ready, bus_err, mem_req, mem_we = 0;
- mem_addr, mem_wdata, rsp_rdata = 0;
- mem_wstrb = 0;
- owner = 0;
- counter and error flag = 0.
REQ-029 Reset asserted mid-transaction abandons it; no ready pulse is produced after reset deasserts.

Configuration
REQ-030 With CIX32_ARB_RR_EN defined, simultaneous requests in IDLE shall be granted to the port that is not owner (round-robin). A single request is always granted immediately. Owner resets to 0, so data wins the first tie.
REQ-031 With CIX32_ARB_RR_EN undefined, the fixed data priority of REQ-027 applies and no round-robin state exists.

Structure
REQ-032 The arb_state_t enum and the OWNER_IF/OWNER_D constants shall live in cix32_defines.sv.
REQ-033 No sub-module; the timeout counter is inline.

Verification
REQ-034 if_req with if_addr=32'h100, mem_ready at the first BUSY cycle with rdata 32'hDEADBEEF -> mem_addr=32'h100, mem_we=0, if_ready one cycle later with rsp_rdata=32'hDEADBEEF.
REQ-035 d_req store to 32'h2000, data 32'h12345678, wstrb 4'b0011 -> mem_we=1 and fields match; d_ready pulses once with bus_err=0.
REQ-036 Both requests held for 4 transactions -> fixed priority gives owner 1,1,1,1; CIX32_ARB_RR_EN gives 1,0,1,0.
REQ-037 TIMEOUT_CYCLES=4, mem_ready held 0 -> abort after the 4th BUSY cycle; d_ready=bus_err=1 with rsp_rdata=32'hFFFF_FFFF, then IDLE.
REQ-038 rst_n pulled low during BUSY -> all outputs return to reset values asynchronously; no ready pulse after release until a new request.
